// File: rtl/alu_ctl_stage.sv
// ALU-control decode stage at the ID/EX boundary: registered decode with stall/flush and
// multi-cycle shift sequencing. Optional illegal-opcode flag under ALU_CTL_ILLEGAL_EN.
//
// state  | meaning
// IDLE   | no live instruction in the stage
// ISSUE  | one live single-cycle instruction
// MULTI  | shift holding EX; cnt counts remaining busy cycles
module alu_ctl_stage #(
  parameter int OP_W      = 6,
  parameter int CTL_W     = 3,
  parameter int SHIFT_LAT = 2,
  parameter int NOP_CODE  = 7
) (
  input  logic             iClk_wire,
  input  logic             iReset_wire,
  input  logic [OP_W-1:0]  iOpcode_wire,
  input  logic             iValid_wire,
  input  logic             iStall_wire,
  input  logic             iFlush_wire,
  output logic             oReady_wire,
  output logic [CTL_W-1:0] oAluctl_reg,
  output logic             oValid_reg,
  output logic             oBusy_reg
`ifdef ALU_CTL_ILLEGAL_EN
  ,
  output logic             oIllegal_reg
`endif
);

  localparam logic [CTL_W-1:0] NOP_C    = CTL_W'(NOP_CODE);
  localparam int               CNT_W    = (SHIFT_LAT > 2) ? $clog2(SHIFT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SHIFT_LAT > 1) ? SHIFT_LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MULTI} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTL_W-1:0] ctl_q, ctl_d, dec_ctl;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             op_hi, is_shift, hold, accept;
  logic [5:0]       op6;

  assign op6 = iOpcode_wire[5:0];

  generate
    if (OP_W > 6) begin : g_op_hi
      assign op_hi = |iOpcode_wire[OP_W-1:6];
    end else begin : g_no_op_hi
      assign op_hi = 1'b0;
    end
  endgenerate

  // Opcode ranges are octal, matching the ISA tables.
  always_comb begin
    dec_ctl = NOP_C;
    if (!op_hi) begin
      if      (op6 <= 6'o05) dec_ctl = CTL_W'(0);
      else if (op6 <= 6'o11) dec_ctl = CTL_W'(1);
      else if (op6 <= 6'o15) dec_ctl = CTL_W'(3);
      else if (op6 <= 6'o21) dec_ctl = CTL_W'(2);
      else if (op6 <= 6'o25) dec_ctl = CTL_W'(5);
      else if (op6 == 6'o26) dec_ctl = CTL_W'(4);
      else if (op6 == 6'o27) dec_ctl = CTL_W'(6);
    end
  end

  assign is_shift    = !op_hi && ((op6 == 6'o26) || (op6 == 6'o27));
  assign hold        = (state_q == S_MULTI) && (cnt_q != '0);
  assign oReady_wire = !iStall_wire && !hold;
  assign accept      = iValid_wire && oReady_wire && !iFlush_wire;

`ifdef ALU_CTL_ILLEGAL_EN
  logic illegal_q, illegal_d;
  assign oIllegal_reg = illegal_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    valid_d = valid_q;
    busy_d  = busy_q;
`ifdef ALU_CTL_ILLEGAL_EN
    illegal_d = illegal_q;
`endif
    if (iFlush_wire) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ctl_d   = NOP_C;
      valid_d = 1'b0;
      busy_d  = 1'b0;
`ifdef ALU_CTL_ILLEGAL_EN
      illegal_d = 1'b0;
`endif
    end else if (iStall_wire) begin
      state_d = state_q;
    end else if (hold) begin
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
    end else if (accept) begin
      ctl_d   = dec_ctl;
      valid_d = 1'b1;
`ifdef ALU_CTL_ILLEGAL_EN
      illegal_d = op_hi || (op6 > 6'o45);
`endif
      if (is_shift && (SHIFT_LAT > 1)) begin
        state_d = S_MULTI;
        cnt_d   = CNT_LOAD;
        busy_d  = 1'b1;
      end else begin
        state_d = S_ISSUE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    end else begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ctl_d   = NOP_C;
      valid_d = 1'b0;
      busy_d  = 1'b0;
`ifdef ALU_CTL_ILLEGAL_EN
      illegal_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge iClk_wire) begin
    if (iReset_wire) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctl_q   <= NOP_C;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ALU_CTL_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef ALU_CTL_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign oAluctl_reg = ctl_q;
  assign oValid_reg  = valid_q;
  assign oBusy_reg   = busy_q;

endmodule

// File: tb/tb_alu_ctl_stage.sv
// Scoreboard bench for alu_ctl_stage (SHIFT_LAT=3, OP_W=8). Each row gives this cycle's
// inputs and the outputs expected while those inputs are applied.
module tb_alu_ctl_stage;
  localparam int OP_W = 8;
  localparam int CTL_W = 3;
  localparam int SHIFT_LAT = 3;
  localparam int NOP_CODE = 7;

  logic clk = 1'b0;
  logic rst, vld_in, stall, flush;
  logic [OP_W-1:0] op;
  logic rdy, vld_out, busy;
  logic [CTL_W-1:0] ctl;
`ifdef ALU_CTL_ILLEGAL_EN
  logic ill;
`endif

  always #5 clk = ~clk;

  alu_ctl_stage #(
    .OP_W(OP_W), .CTL_W(CTL_W), .SHIFT_LAT(SHIFT_LAT), .NOP_CODE(NOP_CODE)
  ) dut (
    .iClk_wire(clk),
    .iReset_wire(rst),
    .iOpcode_wire(op),
    .iValid_wire(vld_in),
    .iStall_wire(stall),
    .iFlush_wire(flush),
    .oReady_wire(rdy),
    .oAluctl_reg(ctl),
    .oValid_reg(vld_out),
    .oBusy_reg(busy)
`ifdef ALU_CTL_ILLEGAL_EN
    ,
    .oIllegal_reg(ill)
`endif
  );

  typedef struct {
    int         row;
    logic [2:0] ctl;
    logic       vld;
    logic       busy;
    logic       rdy;
    logic       ill;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int row_n = 0;

  task automatic step(input logic r, input logic v, input logic [OP_W-1:0] o,
                      input logic st, input logic fl, input logic [2:0] e_ctl,
                      input logic e_vld, input logic e_busy, input logic e_rdy,
                      input logic e_ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; vld_in = v; op = o; stall = st; flush = fl;
    e.row = row_n; e.ctl = e_ctl; e.vld = e_vld; e.busy = e_busy; e.rdy = e_rdy; e.ill = e_ill;
    sb_q.push_back(e);
    row_n++;
  endtask

  // Monitor: compares one expected entry per cycle, away from the active edge.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        bad = 1'b0;
        n_vec++;
        if (ctl !== e.ctl) begin
          $display("FAIL row%0d aluctl got %0d want %0d", e.row, ctl, e.ctl); bad = 1'b1;
        end
        if (vld_out !== e.vld) begin
          $display("FAIL row%0d valid got %b want %b", e.row, vld_out, e.vld); bad = 1'b1;
        end
        if (busy !== e.busy) begin
          $display("FAIL row%0d busy got %b want %b", e.row, busy, e.busy); bad = 1'b1;
        end
        if (rdy !== e.rdy) begin
          $display("FAIL row%0d ready got %b want %b", e.row, rdy, e.rdy); bad = 1'b1;
        end
`ifdef ALU_CTL_ILLEGAL_EN
        if (ill !== e.ill) begin
          $display("FAIL row%0d illegal got %b want %b", e.row, ill, e.ill); bad = 1'b1;
        end
`endif
        if (bad) n_bad++;
      end
    end
  end

  initial begin
    rst = 1'b1; vld_in = 1'b0; op = '0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    //    rst  v   opcode  st  fl   ctl vld bsy rdy ill
    step(1, 1, 8'o06,  0, 0,  7, 0, 0, 1, 0);  // reset held with valid 06
    step(0, 1, 8'o06,  0, 0,  7, 0, 0, 1, 0);
    step(0, 1, 8'o00,  0, 0,  1, 1, 0, 1, 0);
    step(0, 1, 8'o07,  0, 0,  0, 1, 0, 1, 0);
    step(0, 1, 8'o13,  0, 0,  1, 1, 0, 1, 0);
    step(0, 1, 8'o17,  0, 0,  3, 1, 0, 1, 0);
    step(0, 1, 8'o22,  0, 0,  2, 1, 0, 1, 0);
    step(0, 1, 8'o30,  0, 0,  5, 1, 0, 1, 0);
    step(0, 0, 8'o00,  0, 0,  7, 1, 0, 1, 0);
    step(0, 1, 8'o26,  0, 0,  7, 0, 0, 1, 0);  // ASLA issue
    step(0, 1, 8'o06,  0, 0,  4, 1, 1, 0, 0);
    step(0, 1, 8'o06,  0, 0,  4, 1, 1, 0, 0);
    step(0, 1, 8'o06,  0, 0,  4, 1, 0, 1, 0);
    step(0, 0, 8'o00,  0, 0,  1, 1, 0, 1, 0);
    step(0, 1, 8'o27,  0, 0,  7, 0, 0, 1, 0);  // ASRA with a mid-shift stall
    step(0, 1, 8'o06,  0, 0,  6, 1, 1, 0, 0);
    step(0, 1, 8'o06,  1, 0,  6, 1, 1, 0, 0);
    step(0, 1, 8'o06,  0, 0,  6, 1, 1, 0, 0);
    step(0, 1, 8'o06,  0, 0,  6, 1, 0, 1, 0);
    step(0, 1, 8'o12,  0, 0,  1, 1, 0, 1, 0);
    step(0, 1, 8'o12,  1, 0,  3, 1, 0, 0, 0);
    step(0, 1, 8'o12,  1, 0,  3, 1, 0, 0, 0);
    step(0, 1, 8'o12,  1, 1,  3, 1, 0, 0, 0);  // flush beats stall
    step(0, 1, 8'o27,  0, 0,  7, 0, 0, 1, 0);
    step(0, 0, 8'o00,  0, 1,  6, 1, 1, 0, 0);  // flush mid-shift
    step(0, 0, 8'o00,  0, 0,  7, 0, 0, 1, 0);
    step(0, 1, 8'o05,  0, 1,  7, 0, 0, 1, 0);  // flush discards valid opcode
    step(0, 1, 8'o21,  0, 0,  7, 0, 0, 1, 0);
    step(0, 1, 8'o26,  0, 0,  2, 1, 0, 1, 0);
    step(1, 1, 8'o06,  0, 0,  4, 1, 1, 0, 0);  // reset aborts the shift
    step(0, 1, 8'o46,  0, 0,  7, 0, 0, 1, 0);
    step(0, 1, 8'o77,  0, 0,  7, 1, 0, 1, 1);
    step(0, 1, 8'o00,  0, 0,  7, 1, 0, 1, 1);
    step(0, 1, 8'o45,  0, 0,  0, 1, 0, 1, 0);
    step(0, 1, 8'o106, 0, 0,  7, 1, 0, 1, 0);  // bit 6 set: not an ASLA/add
    step(0, 0, 8'o00,  0, 0,  7, 1, 0, 1, 1);
    step(0, 0, 8'o00,  0, 0,  7, 0, 0, 1, 0);
    begin
      int guard;
      guard = 0;
      while (sb_q.size() > 0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      #1;
      if (sb_q.size() > 0) begin
        $display("FAIL drain %0d entries left, want 0", sb_q.size());
        n_bad++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_ctl_stage.md
# alu_ctl_stage

Registered, parametrised ALU-control decode stage sitting at the ID/EX boundary of the pipelined processor. It decodes the instruction opcode into the 3-bit ALU operation code, registers it with a valid flag, and honours pipeline stall and flush. It also sequences multi-cycle shift operations (ASLA/ASRA) by holding the issued control word and back-pressuring ID for a configurable number of cycles.

## Interface
Parameters:
- OP_W, 6: opcode width; must be ≥ 6.
- CTL_W, 3: ALU control width; must be ≥ 3, codes zero-extended.
- SHIFT_LAT, 2: EX cycles a shift occupies; 1 means single-cycle.
- NOP_CODE, 7: control value driven for bubbles and no-ALU instructions.

Ports:
- iClk_wire, in, 1: clock, rising edge. One clock domain.
- iReset_wire, in, 1: reset, synchronous, active-high.
- iOpcode_wire, in, OP_W: opcode from ID.
- iValid_wire, in, 1: ID presents a valid opcode.
- iStall_wire, in, 1: downstream stall; all state holds.
- iFlush_wire, in, 1: squash the stage (taken branch/jump).
- oReady_wire, out, 1: combinational; stage accepts this cycle.
- oAluctl_reg, out, CTL_W: registered ALU operation.
- oValid_reg, out, 1: oAluctl_reg belongs to a live instruction.
- oBusy_reg, out, 1: multi-cycle shift still occupying EX.
- oIllegal_reg, out, 1: only with ALU_CTL_ILLEGAL_EN; see Configuration.

## Operation
- Decode (octal opcode → code): 00–05 → 0 (loads/stores); 06–11 → 1 (add); 12–15 → 3 (sub); 16–21 → 2 (and); 22–25 → 5 (or); 26 → 4 (ASLA); 27 → 6 (ASRA); 30–45 → NOP_CODE (jumps/branches/NOP). Any other value, including any nonzero bit above bit 5, → NOP_CODE.
- oReady_wire = !iStall_wire && !(state==MULTI && cnt!=0).
- Accept: iValid_wire && oReady_wire && !iFlush_wire.
- States:
  - IDLE: no live instruction. Accept → ISSUE, or → MULTI if the code is 4 or 6 and SHIFT_LAT>1 (cnt loaded with SHIFT_LAT-1).
  - ISSUE: one live instruction. Accept → ISSUE or MULTI as above; no accept and no stall → IDLE.
  - MULTI: oAluctl_reg and oValid_reg hold. cnt decrements on each non-stalled cycle. While cnt!=0, oBusy_reg=1 and nothing is accepted. At cnt==0, transitions follow ISSUE rules.
- Priority per edge: reset > flush > stall > accept > bubble.
  - Flush: next state IDLE; oValid_reg=0; oAluctl_reg=NOP_CODE; cnt=0; oBusy_reg=0. Stall is ignored.
  - Stall (no flush): every register holds, including cnt.
  - Bubble (no accept, not stalled, not MULTI-holding): oValid_reg=0; oAluctl_reg=NOP_CODE.
- NOP-class opcodes are accepted normally: oValid_reg=1, oAluctl_reg=NOP_CODE.

## Timing
- Reset values: state IDLE; oAluctl_reg=NOP_CODE; oValid_reg=0; oBusy_reg=0; oIllegal_reg=0; cnt=0. Reset mid-shift aborts the shift immediately.
- Latency: opcode accepted at edge N appears on oAluctl_reg/oValid_reg after edge N.
- Single-cycle throughput: back-to-back accepts with no bubbles.
- A shift with SHIFT_LAT=L holds its code for exactly L cycles (stall cycles excluded). oBusy_reg is high for the first L-1 of them. oReady_wire rises in the L-th cycle, so the next instruction issues with no extra bubble.
- Stall while MULTI with cnt==1: cnt stays 1 until the stall drops.
- Flush arriving together with iValid_wire: the opcode is discarded.

## Configuration
- ALU_CTL_ILLEGAL_EN defined:
  - oIllegal_reg is registered with the same priority and timing as oValid_reg.
  - It is set to 1 for an accepted opcode outside 00–45.
  - Decoded output is still NOP_CODE with oValid_reg=1.
  - It clears on the next accept, bubble, flush or reset, and holds on stall.
- ALU_CTL_ILLEGAL_EN undefined: port oIllegal_reg is absent; undefined opcodes decode silently to NOP_CODE.

## Test plan
- Reset with iValid_wire=1, opcode 06 → during reset oAluctl_reg=7, oValid_reg=0, oBusy_reg=0; the first edge after release latches code 1.
- Back-to-back stream 00, 07, 13, 17, 22, 30 → oAluctl_reg 0, 1, 3, 2, 5, 7 on consecutive cycles, all with oValid_reg=1.
- SHIFT_LAT=3, opcode 26 then 06 held valid:
  - code 4 for 3 cycles, oBusy_reg=1 for 2 cycles, oReady_wire=0 for 2 cycles;
  - code 1 on the next cycle.
  - Repeat with one stall mid-shift: the hold extends to 4 cycles.
- Opcode 12 with iStall_wire=1 for 2 cycles → output held at 3/valid for those cycles; iFlush_wire together with iStall_wire → next cycle oValid_reg=0, oAluctl_reg=7.
- Flush during MULTI (opcode 27, flush on the 2nd cycle) → next cycle IDLE, oBusy_reg=0, oReady_wire=1.
- With ALU_CTL_ILLEGAL_EN, opcodes 46 and 77 → oIllegal_reg=1, oAluctl_reg=7; following opcode 00 → oIllegal_reg=0, code 0.
